// File: rtl/mp3_pkg.sv
// Shared constants for the VS10xx-style SPI command/data link.
package mp3_pkg;

  localparam logic [7:0] SCI_OP_WRITE = 8'h02;
  localparam logic [7:0] SCI_OP_READ  = 8'h03;

  localparam logic [3:0] SCI_MODE = 4'h0;
  localparam logic [3:0] SCI_VOL  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCI_HDR,
    ST_SCI_WR,
    ST_SCI_RD,
    ST_SCI_END,
    ST_SDI_RX,
    ST_ERR_WAIT
  } state_t;

endpackage

// File: rtl/vs_sdi_fifo.sv
// Synchronous word FIFO for SDI audio data; pointers carry a wrap bit.
module vs_sdi_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 16
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign free  = DEPTH_W - (wptr - rptr);
  assign head  = mem[rptr[AW-1:0]];

  // a pop frees a slot this cycle, so a push against a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // pointer update
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage write; contents are don't-care once pointers are reset
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vs_spi_responder.sv
// VS10xx-style SPI slave: SCI register access on XCS, SDI word stream on XDCS.
module vs_spi_responder
  import mp3_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 64,
  parameter int          DREQ_FREE   = 16,
  parameter int          BUSY_CYCLES = 100,
  parameter logic [15:0] MODE_RST    = 16'h0800
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_SCK,
  input  logic        i_SI,
  input  logic        i_XCS,
  input  logic        i_XDCS,
  output logic        o_SO,
  output logic        o_DREQ,
  output logic [15:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_reg_wr,
  output logic [3:0]  o_reg_addr,
  output logic [15:0] o_reg_wdata,
  output logic        o_err
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(BUSY_CYCLES + 1);
  localparam logic [FAW:0]  DREQ_FREE_W = DREQ_FREE[FAW:0];
  localparam logic [BW-1:0] BUSY_LD     = BUSY_CYCLES[BW-1:0];

  logic [1:0] sck_q, si_q, xcs_q, xdcs_q;
  logic       sck_d;
  logic       sck_s, si_s, xcs, xdcs, rise, fall;

  state_t      state;
  logic [3:0]  cnt, addr;
  logic [14:0] sh;
  logic [15:0] rd_sh;
  logic [15:0] regs [16];
  logic [BW-1:0] busy;
  logic        push_req;
  logic [15:0] push_word;

  logic        f_full, f_empty, drop;
  logic [FAW:0] f_free;
  logic [15:0] word;
  logic [7:0]  hdr_op;
  logic [3:0]  hdr_addr;

  assign sck_s = sck_q[1];
  assign si_s  = si_q[1];
  assign xcs   = xcs_q[1];
  assign xdcs  = xdcs_q[1];
  assign rise  = sck_s & ~sck_d;
  assign fall  = ~sck_s & sck_d;

  // word as it stands once the current bit is shifted in
  assign word     = {sh, si_s};
  assign hdr_op   = sh[14:7];
  assign hdr_addr = {sh[2:0], si_s};

  // a word reaching a full FIFO with no simultaneous pop is lost
  assign drop = push_req & f_full & ~(i_data_ready & ~f_empty);

  // selects idle high so a reset does not look like a double select
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      si_q   <= '0;
      xcs_q  <= 2'b11;
      xdcs_q <= 2'b11;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[0], i_SCK};
      si_q   <= {si_q[0], i_SI};
      xcs_q  <= {xcs_q[0], i_XCS};
      xdcs_q <= {xdcs_q[0], i_XDCS};
      sck_d  <= sck_s;
    end
  end

  // frame decoder, register file and busy timer
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr        <= '0;
      sh          <= '0;
      rd_sh       <= '0;
      busy        <= '0;
      push_req    <= 1'b0;
      push_word   <= '0;
      o_SO        <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_err       <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= (4'(i) == SCI_MODE) ? MODE_RST : 16'h0000;
    end else begin
      o_reg_wr <= 1'b0;
      push_req <= 1'b0;
      o_err    <= drop;
      if (busy != '0) busy <= busy - BW'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!xcs && !xdcs) begin
            o_err <= 1'b1;
            state <= ST_ERR_WAIT;
          end else if (!xcs) state <= ST_SCI_HDR;
          else if (!xdcs)    state <= ST_SDI_RX;
        end
        ST_SCI_HDR: begin
          if (xcs) state <= ST_IDLE;
          else if (rise) begin
            sh  <= word[14:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              addr <= hdr_addr;
              if (hdr_op == SCI_OP_WRITE) state <= ST_SCI_WR;
              else if (hdr_op == SCI_OP_READ) begin
                rd_sh <= regs[hdr_addr];
                state <= ST_SCI_RD;
              end else begin
                o_err <= 1'b1;
                state <= ST_SCI_END;
              end
            end
          end
        end
        ST_SCI_WR: begin
          if (xcs) state <= ST_IDLE;
          else if (rise) begin
            sh  <= word[14:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              regs[addr]  <= word;
              o_reg_wr    <= 1'b1;
              o_reg_addr  <= addr;
              o_reg_wdata <= word;
              busy        <= BUSY_LD;
              state       <= ST_SCI_END;
            end
          end
        end
        ST_SCI_RD: begin
          if (xcs) begin
            o_SO  <= 1'b0;
            state <= ST_IDLE;
          end else if (fall) begin
            o_SO  <= rd_sh[15];
            rd_sh <= {rd_sh[14:0], 1'b0};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd15) state <= ST_SCI_END;
          end
        end
        ST_SCI_END: begin
          // bit 0 stays on SO until the master has sampled it on the last rise
          if (xcs) begin
            o_SO  <= 1'b0;
            state <= ST_IDLE;
          end else if (fall) o_SO <= 1'b0;
        end
        ST_SDI_RX: begin
          if (xdcs) state <= ST_IDLE;
          else if (rise) begin
            sh  <= word[14:0];
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              push_req  <= 1'b1;
              push_word <= word;
            end
          end
        end
        ST_ERR_WAIT: if (xcs && xdcs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // DREQ: no write busy window and enough room for another burst
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) o_DREQ <= 1'b0;
    else     o_DREQ <= (busy == '0) && (f_free >= DREQ_FREE_W);
  end

  vs_sdi_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_word),
    .pop       (i_data_ready),
    .head      (o_data),
    .full      (f_full),
    .empty     (f_empty),
    .free      (f_free)
  );

  assign o_data_valid = ~f_empty;

endmodule

// File: tb/tb_vs_spi_responder.sv
// Directed bench for vs_spi_responder: SCI register access, SDI FIFO, DREQ, errors.
module tb_vs_spi_responder;
  import mp3_pkg::*;

  localparam int H = 10; // SCK half period in CLK cycles (SCK = CLK/20)

  logic        CLK = 0, rst = 1;
  logic        i_SCK = 0, i_SI = 0, i_XCS = 1, i_XDCS = 1, i_data_ready = 0;
  logic        o_SO, o_DREQ, o_data_valid, o_reg_wr, o_err;
  logic [15:0] o_data, o_reg_wdata;
  logic [3:0]  o_reg_addr;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, err_cnt = 0, wr_cnt = 0, wr_cyc = 0;
  logic [3:0]  last_addr;
  logic [15:0] last_wdata;

  vs_spi_responder dut (
    .CLK(CLK), .rst(rst), .i_SCK(i_SCK), .i_SI(i_SI), .i_XCS(i_XCS), .i_XDCS(i_XDCS),
    .o_SO(o_SO), .o_DREQ(o_DREQ), .o_data(o_data), .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready), .o_reg_wr(o_reg_wr), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .o_err(o_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // pulse monitor
  always @(negedge CLK) begin
    if (o_err) err_cnt++;
    if (o_reg_wr) begin
      wr_cnt++;
      wr_cyc     = cyc;
      last_addr  = o_reg_addr;
      last_wdata = o_reg_wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sci_xfer(input logic [31:0] tx, input int nbits, output logic [15:0] rx);
    rx = '0;
    i_XCS = 0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      i_SI = tx[31-i];
      tick(H);
      if (i >= 16) rx = {rx[14:0], o_SO};
      i_SCK = 1;
      tick(H);
      i_SCK = 0;
    end
    tick(H);
    i_XCS = 1;
    i_SI  = 0;
    tick(8);
  endtask

  task automatic sdi_bits(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      i_SI = w[15-i];
      tick(H);
      i_SCK = 1;
      tick(H);
      i_SCK = 0;
    end
  endtask

  task automatic sdi_word(input logic [15:0] w);
    i_XDCS = 0;
    tick(4);
    sdi_bits(w);
    tick(H);
    i_XDCS = 1;
    tick(8);
  endtask

  task automatic test_reset;
    logic [15:0] rx;
    rst = 1;
    tick(3);
    n_cmp++; if (o_DREQ !== 1'b0) begin $display("FAIL reset_dreq: got %b want 0", o_DREQ); n_bad++; end
    n_cmp++; if (o_data_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", o_data_valid); n_bad++; end
    n_cmp++; if ({o_SO, o_reg_wr, o_err} !== 3'b000) begin $display("FAIL reset_pulses: got %b want 000", {o_SO, o_reg_wr, o_err}); n_bad++; end
    rst = 0;
    tick(200);
    n_cmp++; if (o_DREQ !== 1'b1) begin $display("FAIL idle_dreq: got %b want 1", o_DREQ); n_bad++; end
    n_cmp++; if (o_data_valid !== 1'b0) begin $display("FAIL idle_valid: got %b want 0", o_data_valid); n_bad++; end
    sci_xfer({SCI_OP_READ, 4'h0, SCI_MODE, 16'h0000}, 32, rx);
    n_cmp++; if (rx !== 16'h0800) begin $display("FAIL read_mode_reset: got %h want 0800", rx); n_bad++; end
  endtask

  task automatic test_write;
    logic [15:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    sci_xfer(32'h020B0000, 32, rx);
    n_cmp++; if (wr_cnt - w0 !== 1) begin $display("FAIL write_strobes: got %0d want 1", wr_cnt - w0); n_bad++; end
    n_cmp++; if ({last_addr, last_wdata} !== {SCI_VOL, 16'h0000}) begin $display("FAIL write_fields: got %h/%h want b/0000", last_addr, last_wdata); n_bad++; end
    n_cmp++; if (err_cnt !== e0) begin $display("FAIL write_err: got %0d want %0d", err_cnt, e0); n_bad++; end
    n_cmp++; if (o_DREQ !== 1'b0) begin $display("FAIL busy_dreq_early: got %b want 0", o_DREQ); n_bad++; end
    tick(wr_cyc + 95 - cyc);
    n_cmp++; if (o_DREQ !== 1'b0) begin $display("FAIL busy_dreq_95: got %b want 0", o_DREQ); n_bad++; end
    tick(10);
    n_cmp++; if (o_DREQ !== 1'b1) begin $display("FAIL busy_dreq_105: got %b want 1", o_DREQ); n_bad++; end
  endtask

  task automatic test_read;
    logic [15:0] rx;
    sci_xfer(32'h030B0000, 32, rx);
    n_cmp++; if (rx !== 16'h0000) begin $display("FAIL read_vol0: got %h want 0000", rx); n_bad++; end
    sci_xfer(32'h020B1234, 32, rx);
    n_cmp++; if (last_wdata !== 16'h1234) begin $display("FAIL write_1234: got %h want 1234", last_wdata); n_bad++; end
    sci_xfer(32'h03FBFFFF, 32, rx); // address high nibble ignored
    n_cmp++; if (rx !== 16'h1234) begin $display("FAIL read_1234: got %h want 1234", rx); n_bad++; end
    n_cmp++; if (o_SO !== 1'b0) begin $display("FAIL so_idle: got %b want 0", o_SO); n_bad++; end
  endtask

  task automatic test_sdi;
    i_XDCS = 0;
    tick(4);
    sdi_bits(16'hFEFE);
    sdi_bits(16'h0102);
    tick(H);
    i_XDCS = 1;
    tick(8);
    n_cmp++; if (o_data_valid !== 1'b1) begin $display("FAIL sdi_valid: got %b want 1", o_data_valid); n_bad++; end
    n_cmp++; if (o_data !== 16'hFEFE) begin $display("FAIL sdi_head0: got %h want fefe", o_data); n_bad++; end
    i_data_ready = 1; tick(1); i_data_ready = 0;
    n_cmp++; if (o_data !== 16'h0102) begin $display("FAIL sdi_head1: got %h want 0102", o_data); n_bad++; end
    i_data_ready = 1; tick(1); i_data_ready = 0;
    n_cmp++; if (o_data_valid !== 1'b0) begin $display("FAIL sdi_drained: got %b want 0", o_data_valid); n_bad++; end
  endtask

  task automatic test_full;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 48; k++) sdi_word(16'hA500 + 16'(k));
    n_cmp++; if (o_DREQ !== 1'b1) begin $display("FAIL dreq_free16: got %b want 1", o_DREQ); n_bad++; end
    sdi_word(16'hA530);
    n_cmp++; if (o_DREQ !== 1'b0) begin $display("FAIL dreq_free15: got %b want 0", o_DREQ); n_bad++; end
    for (int k = 49; k < 64; k++) sdi_word(16'hA500 + 16'(k));
    n_cmp++; if (err_cnt !== e0) begin $display("FAIL fill_err: got %0d want %0d", err_cnt, e0); n_bad++; end
    sdi_word(16'hDEAD);
    n_cmp++; if (err_cnt - e0 !== 1) begin $display("FAIL overflow_err: got %0d want 1", err_cnt - e0); n_bad++; end
    i_data_ready = 1;
    for (int k = 0; k < 64; k++) begin
      n_cmp++; if ({o_data_valid, o_data} !== {1'b1, 16'hA500 + 16'(k)}) begin
        $display("FAIL drain_%0d: got %b/%h want 1/%h", k, o_data_valid, o_data, 16'hA500 + 16'(k)); n_bad++;
      end
      tick(1);
    end
    i_data_ready = 0;
    n_cmp++; if (o_data_valid !== 1'b0) begin $display("FAIL drain_count: got valid %b want 0", o_data_valid); n_bad++; end
  endtask

  task automatic test_errors;
    logic [15:0] rx;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    sci_xfer(32'h020B5555, 20, rx); // abort after 20 bits
    n_cmp++; if (err_cnt !== e0) begin $display("FAIL abort_err: got %0d want %0d", err_cnt, e0); n_bad++; end
    i_XCS = 0; i_XDCS = 0;
    tick(10);
    i_XCS = 1; i_XDCS = 1;
    tick(10);
    n_cmp++; if (err_cnt - e0 !== 1) begin $display("FAIL dual_sel_err: got %0d want 1", err_cnt - e0); n_bad++; end
    sci_xfer(32'h050B7777, 32, rx);
    n_cmp++; if (err_cnt - e0 !== 2) begin $display("FAIL bad_op_err: got %0d want 2", err_cnt - e0); n_bad++; end
    n_cmp++; if (wr_cnt !== w0) begin $display("FAIL err_no_write: got %0d want %0d", wr_cnt, w0); n_bad++; end
    sci_xfer(32'h030B0000, 32, rx);
    n_cmp++; if (rx !== 16'h1234) begin $display("FAIL vol_kept: got %h want 1234", rx); n_bad++; end
  endtask

  task automatic test_reset_mid;
    sdi_word(16'h1111);
    i_XDCS = 0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      i_SI = 1; tick(H); i_SCK = 1; tick(H); i_SCK = 0;
    end
    rst = 1;
    tick(2);
    n_cmp++; if ({o_data_valid, o_DREQ} !== 2'b00) begin $display("FAIL midreset_state: got %b want 00", {o_data_valid, o_DREQ}); n_bad++; end
    i_XDCS = 1; i_SI = 0;
    rst = 0;
    tick(10);
    sdi_word(16'h2468);
    n_cmp++; if ({o_data_valid, o_data} !== {1'b1, 16'h2468}) begin $display("FAIL midreset_head: got %b/%h want 1/2468", o_data_valid, o_data); n_bad++; end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_sdi;
    test_full;
    test_errors;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
